// File: rtl/fpu_mul_pkg.sv
// Shared constants and FSM encoding for the
// multiplier sum/carry resolve stage.
package fpu_mul_pkg;

  localparam int PROD_W = 48;
  localparam int MANT_W = 24;
  localparam int CHUNK  = 12;
  localparam int NCHUNK = PROD_W / CHUNK;
  localparam int CNT_W  = $clog2(NCHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/add_chunk.sv
// One slice of the carry-propagate adder,
// reused across cycles by the resolve stage.
module add_chunk
  import fpu_mul_pkg::*;
#(
  parameter int W = CHUNK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // plain ripple sum of one slice with carry in/out
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mant_sc_resolve.sv
// Resolves the tree's redundant product chunk by chunk,
// then normalises and rounds it to nearest-even.
module mant_sc_resolve
  import fpu_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] s_in,
  input  logic [PROD_W-1:0] c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant,
  output logic [1:0]        exp_adj,
  output logic              inexact
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [PROD_W-1:0]  s_r, c_r, p_r;
  logic [CHUNK-1:0]   sl_sum;
  logic               sl_cout;

  logic               hi;
  logic [MANT_W-1:0]  m;
  logic               g, st, rnd;
  logic [MANT_W:0]    m_inc;
  logic [MANT_W-1:0]  mant_n;
  logic [1:0]         e_n;

  add_chunk #(.W(CHUNK)) u_add (
    .a    (s_r[cnt*CHUNK +: CHUNK]),
    .b    (c_r[cnt*CHUNK +: CHUNK]),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid)    state_n = ADD;
      ADD:  if (cnt == LAST) state_n = NORM;
      NORM:                  state_n = DONE;
      DONE: if (out_ready)   state_n = IDLE;
      default:               state_n = IDLE;
    endcase
  end

  // normalise on the top bit, round to nearest-even
  always_comb begin
    hi     = p_r[PROD_W-1];
    m      = hi ? p_r[PROD_W-1 -: MANT_W] : p_r[PROD_W-2 -: MANT_W];
    g      = hi ? p_r[PROD_W-MANT_W-1] : p_r[PROD_W-MANT_W-2];
    st     = hi ? |p_r[PROD_W-MANT_W-2:0] : |p_r[PROD_W-MANT_W-3:0];
    rnd    = g & (st | m[0]);
    m_inc  = {1'b0, m} + {{MANT_W{1'b0}}, rnd};
    e_n    = {1'b0, hi};
    mant_n = m_inc[MANT_W-1:0];
    if (m_inc[MANT_W]) begin
      mant_n = {1'b1, {(MANT_W-1){1'b0}}};
      e_n    = e_n + 2'd1;
    end
  end

  // operand capture, slice accumulation, result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r     <= '0;
      c_r     <= '0;
      p_r     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      mant    <= '0;
      exp_adj <= '0;
      inexact <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            s_r   <= s_in;
            c_r   <= c_in;
            cnt   <= '0;
            carry <= 1'b0;
          end
        end
        ADD: begin
          p_r[cnt*CHUNK +: CHUNK] <= sl_sum;
          carry <= sl_cout;
          cnt   <= cnt + 1'b1;
        end
        NORM: begin
          mant    <= mant_n;
          exp_adj <= e_n;
          inexact <= g | st;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule
